// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the fetched word into the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_err,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

    logic [31:0] pc_q,    pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;
    logic        err_q,   err_d;
    logic [31:0] cnt_q,   cnt_d;

    logic [31:0] pc_plus4;
    logic [31:0] word_idx;
    logic        in_range;

    assign pc_plus4 = pc_q + 32'd4;
    assign word_idx = {2'b00, pc_q[31:2]};
    assign in_range = (word_idx < IMEM_WORDS_W) && (pc_q[1:0] == 2'b00);

    // Redirect beats stall, stall beats flush; a stalled flush still bubbles IF/ID.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (redirect) begin
            pc_d    = redirect_target;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (stall) begin
            if (flush) begin
                instr_d = 32'h0;
                pc4_d   = 32'h0;
                valid_d = 1'b0;
            end
        end else if (flush) begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            pc_d    = pc_plus4;
        end else begin
            instr_d = in_range ? imem_rdata : 32'h0;
            pc4_d   = pc_plus4;
            valid_d = in_range;
            pc_d    = pc_plus4;
            if (in_range) begin
                cnt_d = cnt_q + 32'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_err   = err_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a reference model queues the expected state
// for every driven cycle, which is popped and compared after the clock edge.
module tb_if_stage;

    localparam int unsigned WORDS = 32;

    logic        clock = 1'b0;
    logic        reset, stall, flush, redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc, if_id_instr, if_id_pc4, fetch_count;
    logic        if_id_valid, fetch_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;

    if_stage #(.PC_RESET(32'h0), .IMEM_WORDS(WORDS)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .fetch_err(fetch_err),
        .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    // Memory ignores the low address bits, so misaligned/out-of-range
    // reads return a non-zero word the stage must discard.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:2] < 30'(WORDS)) return 32'h2010_0000 + {2'b00, a[31:2]};
        return 32'hDEAD_BEEF;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input exp_t s, input logic rst, input logic stl,
                                   input logic fl, input logic rd, input logic [31:0] tgt);
        exp_t n;
        logic ir;
        n = s;
        ir = (s.pc[31:2] < 30'(WORDS)) && (s.pc[1:0] == 2'b00);
        if (rst) begin
            n.pc = 32'h0; n.instr = 0; n.pc4 = 0; n.valid = 0; n.err = 0; n.cnt = 0;
        end else if (rd) begin
            n.pc = tgt; n.instr = 0; n.pc4 = 0; n.valid = 0;
        end else if (stl) begin
            if (fl) begin n.instr = 0; n.pc4 = 0; n.valid = 0; end
        end else if (fl) begin
            n.instr = 0; n.pc4 = 0; n.valid = 0; n.pc = s.pc + 4;
        end else begin
            n.instr = ir ? 32'h2010_0000 + {2'b00, s.pc[31:2]} : 32'h0;
            n.pc4   = s.pc + 4;
            n.valid = ir;
            n.pc    = s.pc + 4;
            if (ir) n.cnt = s.cnt + 1;
            else    n.err = 1'b1;
        end
        return n;
    endfunction

    task automatic step(input logic rst, input logic stl, input logic fl,
                        input logic rd, input logic [31:0] tgt, input string tag);
        exp_t e;
        m = model(m, rst, stl, fl, rd, tgt);
        sb_q.push_back(m);
        reset = rst; stall = stl; flush = fl; redirect = rd; redirect_target = tgt;
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".pc"},    pc,          e.pc);
        chk({tag, ".addr"},  imem_addr,   e.pc);
        chk({tag, ".instr"}, if_id_instr, e.instr);
        chk({tag, ".pc4"},   if_id_pc4,   e.pc4);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(e.valid));
        chk({tag, ".err"},   32'(fetch_err),   32'(e.err));
        chk({tag, ".cnt"},   fetch_count, e.cnt);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, tag);
    endtask

    initial begin
        m = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, err: 1'b0, cnt: 32'h0};
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        @(negedge clock);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "reset");
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "reset");

        // Free run: first valid instruction on the first edge after reset.
        run(1, "run");
        chk("first_instr", if_id_instr, 32'h2010_0000);
        chk("first_pc4",   if_id_pc4,   32'd4);
        run(1, "run");
        chk("run_cnt2", fetch_count, 32'd2);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "stall");
        chk("stall_pc",    pc,          32'd8);
        chk("stall_instr", if_id_instr, 32'h2010_0001);
        chk("stall_cnt",   fetch_count, 32'd2);
        run(1, "release");
        chk("release_instr", if_id_instr, 32'h2010_0002);
        run(1, "release");
        chk("release_instr2", if_id_instr, 32'h2010_0003);

        // Run off the end of memory.
        run(28, "run_end");
        chk("end_pc",  pc,          32'h80);
        chk("end_cnt", fetch_count, 32'd32);
        run(2, "oob");
        chk("oob_err",   32'(fetch_err),   32'd1);
        chk("oob_valid", 32'(if_id_valid), 32'd0);
        chk("oob_cnt",   fetch_count,      32'd32);

        // Redirect overrides stall and flush.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, "redir40");
        chk("redir40_pc", pc, 32'h40);
        run(1, "redir40_next");
        chk("redir40_instr", if_id_instr, 32'h2010_0010);
        chk("redir40_pc4",   if_id_pc4,   32'h44);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, "flush");
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, "stall_flush");
        run(1, "after_flush");

        // pc+4 wraps to zero on an out-of-range fetch at the top of memory.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "redir_top");
        run(2, "wrap");

        // Misaligned redirect on a clean error flag.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "reset2");
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h06, "redir06");
        chk("redir06_pc",  pc,               32'h06);
        chk("redir06_err", 32'(fetch_err),   32'd0);
        run(1, "misalign");
        chk("misalign_err",   32'(fetch_err),   32'd1);
        chk("misalign_instr", if_id_instr,      32'h0);

        // Reset wins over stall/redirect mid-stream.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, "redir10");
        run(3, "to1c");
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "stall1c");
        chk("stall1c_pc", pc, 32'h1C);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, "reset_mid");
        chk("reset_mid_pc",  pc,             32'h0);
        chk("reset_mid_err", 32'(fetch_err), 32'd0);
        run(1, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
